// File: rtl/tap_pkg.sv
// Shared TAP definitions: state encodings, next-state rule and the IR/DR select bit.
package tap_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned IR_SEL  = 3;

  typedef enum logic [STATE_W-1:0] {
    EX2_DR = 4'h0,
    EX1_DR = 4'h1,
    SH_DR  = 4'h2,
    PA_DR  = 4'h3,
    SEL_IR = 4'h4,
    UPD_DR = 4'h5,
    CAP_DR = 4'h6,
    SEL_DR = 4'h7,
    EX2_IR = 4'h8,
    EX1_IR = 4'h9,
    SH_IR  = 4'hA,
    PA_IR  = 4'hB,
    RTI    = 4'hC,
    UPD_IR = 4'hD,
    CAP_IR = 4'hE,
    TLR    = 4'hF
  } tap_state_t;

  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = TLR;
    case (s)
      TLR:            n = tms ? TLR    : RTI;
      RTI:            n = tms ? SEL_DR : RTI;
      SEL_DR:         n = tms ? SEL_IR : CAP_DR;
      SEL_IR:         n = tms ? TLR    : CAP_IR;
      CAP_DR, SH_DR:  n = tms ? EX1_DR : SH_DR;
      EX1_DR:         n = tms ? UPD_DR : PA_DR;
      PA_DR:          n = tms ? EX2_DR : PA_DR;
      EX2_DR:         n = tms ? UPD_DR : SH_DR;
      CAP_IR, SH_IR:  n = tms ? EX1_IR : SH_IR;
      EX1_IR:         n = tms ? UPD_IR : PA_IR;
      PA_IR:          n = tms ? EX2_IR : PA_IR;
      EX2_IR:         n = tms ? UPD_IR : SH_IR;
      UPD_DR, UPD_IR: n = tms ? SEL_DR : RTI;
      default:        n = TLR;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tap_controller_if.sv
// TAP pin/cell bundle: TMS in, state and IR/DR control strobes out.
interface tap_controller_if;
  import tap_pkg::*;

  logic       TMS;
  tap_state_t State;
  logic       ResetIR;
  logic       ShiftIR;
  logic       ClockIR;
  logic       UpdateIR;
  logic       ShiftDR;
  logic       ClockDR;
  logic       UpdateDR;
  logic       Select;
  logic       Enable;

  modport master (
    input  TMS,
    output State, ResetIR, ShiftIR, ClockIR, UpdateIR,
           ShiftDR, ClockDR, UpdateDR, Select, Enable
  );

  modport slave (
    output TMS,
    input  State, ResetIR, ShiftIR, ClockIR, UpdateIR,
           ShiftDR, ClockDR, UpdateDR, Select, Enable
  );
endinterface

// File: rtl/tap_clock_gate.sv
// Glitch-free TCK gate: enable captured on falling TCK so it is stable while TCK is high.
module tap_clock_gate (
  input  logic TCK,
  input  logic Reset,
  input  logic en_d,
  output logic gclk
);

  logic en_q;

  always_ff @(negedge TCK or posedge Reset) begin
    if (Reset) en_q <= 1'b0;
    else       en_q <= en_d;
  end

  assign gclk = TCK & en_q;

endmodule

// File: rtl/tap_controller.sv
// IEEE 1149.1 TAP controller: state machine plus falling-edge IR/DR strobes and gated clocks.
module tap_controller
  import tap_pkg::*;
(
  input  logic            TCK,
  input  logic            Reset,
  tap_controller_if.master bus
);

  tap_state_t state_q;
  tap_state_t state_d;

  logic reset_ir_c;
  logic shift_ir_c;
  logic shift_dr_c;
  logic update_ir_c;
  logic update_dr_c;
  logic en_ir_c;
  logic en_dr_c;

  logic reset_ir_q;
  logic shift_ir_q;
  logic shift_dr_q;
  logic update_ir_q;
  logic update_dr_q;
  logic enable_q;

  logic clock_ir;
  logic clock_dr;

  always_ff @(posedge TCK or posedge Reset) begin
    if (Reset) state_q <= TLR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    state_d = tap_next(state_q, bus.TMS);
  end

  // State decode feeding the falling-edge strobe register and the clock-gate enables
  always_comb begin
    reset_ir_c  = 1'b0;
    shift_ir_c  = 1'b0;
    shift_dr_c  = 1'b0;
    update_ir_c = 1'b0;
    update_dr_c = 1'b0;
    en_ir_c     = 1'b0;
    en_dr_c     = 1'b0;
    reset_ir_c  = (state_q == TLR);
    shift_ir_c  = (state_q == SH_IR);
    shift_dr_c  = (state_q == SH_DR);
    update_ir_c = (state_q == UPD_IR);
    update_dr_c = (state_q == UPD_DR);
    en_ir_c     = (state_q == CAP_IR) || (state_q == SH_IR);
    en_dr_c     = (state_q == CAP_DR) || (state_q == SH_DR);
  end

  always_ff @(negedge TCK or posedge Reset) begin
    if (Reset) begin
      reset_ir_q  <= 1'b1;
      shift_ir_q  <= 1'b0;
      shift_dr_q  <= 1'b0;
      update_ir_q <= 1'b0;
      update_dr_q <= 1'b0;
      enable_q    <= 1'b0;
    end else begin
      reset_ir_q  <= reset_ir_c;
      shift_ir_q  <= shift_ir_c;
      shift_dr_q  <= shift_dr_c;
      update_ir_q <= update_ir_c;
      update_dr_q <= update_dr_c;
      enable_q    <= shift_ir_c | shift_dr_c;
    end
  end

  tap_clock_gate u_gate_ir (
    .TCK   (TCK),
    .Reset (Reset),
    .en_d  (en_ir_c),
    .gclk  (clock_ir)
  );

  tap_clock_gate u_gate_dr (
    .TCK   (TCK),
    .Reset (Reset),
    .en_d  (en_dr_c),
    .gclk  (clock_dr)
  );

  assign bus.State    = state_q;
  assign bus.Select   = state_q[IR_SEL];
  assign bus.ResetIR  = reset_ir_q;
  assign bus.ShiftIR  = shift_ir_q;
  assign bus.ShiftDR  = shift_dr_q;
  assign bus.UpdateIR = update_ir_q;
  assign bus.UpdateDR = update_dr_q;
  assign bus.Enable   = enable_q;
  assign bus.ClockIR  = clock_ir;
  assign bus.ClockDR  = clock_dr;

endmodule
